gcd_issuer: RTL and testbench



---
 rtl/gcd_issuer.sv | 250 +++++++++++++++++++++++++
 tb/tb_gcd_issuer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gcd_issuer
//  Description : Queues host GCD requests in a small FIFO and issues them one
//                at a time to an external GCD engine. Zero-operand requests
//                are answered locally. The optional WAIT timeout is enabled
//                by defining the GCD_ISSUER_TIMEOUT_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_issuer #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // host request side
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    // engine side
    output logic             gcd_valid_o,
    output logic [WIDTH-1:0] gcd_a_o,
    output logic [WIDTH-1:0] gcd_b_o,
    input  logic             gcd_done_i,
    input  logic [WIDTH-1:0] gcd_result_i,
    // response side
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_a_o,
    output logic [WIDTH-1:0] rsp_b_o,
    output logic [WIDTH-1:0] rsp_gcd_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL_COUNT = C_CNT_W'(DEPTH);

    // Out-of-range timeout settings leave an empty marker scope in the
    // elaborated hierarchy so they are easy to spot during integration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic             w_head_zero;

    // FSM-generated load strobes
    logic w_issue_load;
    logic w_zero_load;
    logic w_done_load;
    logic w_timeout_load;
    logic w_timeout;

    // datapath registers
    logic [WIDTH-1:0] r_gcd_a;
    logic [WIDTH-1:0] r_gcd_b;
    logic [WIDTH-1:0] r_rsp_a;
    logic [WIDTH-1:0] r_rsp_b;
    logic [WIDTH-1:0] r_rsp_gcd;

    assign w_full      = (r_count == C_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_push      = req_valid_i && !w_full;
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];
    assign w_head_zero = (w_head_a == '0) || (w_head_b == '0);

    // FIFO: write at wr_ptr, read at rd_ptr, pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= req_a_i;
                r_mem_b[r_wr_ptr] <= req_b_i;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GCD_ISSUER_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;
    logic        r_rsp_err;

    // WAIT-cycle counter: cleared in ISSUE so it starts at zero on entering WAIT
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // The last allowed WAIT cycle is the one where the counter shows TIMEOUT_CYCLES-1
    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == C_TIMEOUT_LAST);

    // Error flag: set on expiry, cleared whenever a new response is prepared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout_load) begin
            r_rsp_err <= 1'b1;
        end else if (w_issue_load || w_zero_load) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign rsp_err_o = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and load strobes; engine done has priority over expiry
    always_comb begin
        w_next         = r_state;
        w_pop          = 1'b0;
        w_issue_load   = 1'b0;
        w_zero_load    = 1'b0;
        w_done_load    = 1'b0;
        w_timeout_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_zero) begin
                        w_pop       = 1'b1;
                        w_zero_load = 1'b1;
                        w_next      = S_RESP;
                    end else begin
                        w_issue_load = 1'b1;
                        w_next       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_pop  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (gcd_done_i) begin
                    w_done_load = 1'b1;
                    w_next      = S_RESP;
                end else if (w_timeout) begin
                    w_timeout_load = 1'b1;
                    w_next         = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/result capture; the head is latched on the way into ISSUE so the
    // engine operands are already valid during the ISSUE pulse and held after
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gcd_a   <= '0;
            r_gcd_b   <= '0;
            r_rsp_a   <= '0;
            r_rsp_b   <= '0;
            r_rsp_gcd <= '0;
        end else begin
            if (w_issue_load) begin
                r_gcd_a <= w_head_a;
                r_gcd_b <= w_head_b;
                r_rsp_a <= w_head_a;
                r_rsp_b <= w_head_b;
            end
            if (w_zero_load) begin
                r_rsp_a   <= w_head_a;
                r_rsp_b   <= w_head_b;
                r_rsp_gcd <= w_head_a | w_head_b;
            end
            if (w_done_load) begin
                r_rsp_gcd <= gcd_result_i;
            end else if (w_timeout_load) begin
                r_rsp_gcd <= '0;
            end
        end
    end

    assign req_ready_o = !w_full;
    assign gcd_valid_o = (r_state == S_ISSUE);
    assign gcd_a_o     = r_gcd_a;
    assign gcd_b_o     = r_gcd_b;
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_a_o     = r_rsp_a;
    assign rsp_b_o     = r_rsp_b;
    assign rsp_gcd_o   = r_rsp_gcd;
    assign busy_o      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_gcd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_issuer
//  Description : Scoreboard bench for gcd_issuer. Stimulus pushes expected
//                issues and responses into queues; an engine model and a
//                response monitor pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_issuer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         gcd_valid;
    logic [W-1:0] gcd_a;
    logic [W-1:0] gcd_b;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_a;
    logic [W-1:0] rsp_b;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic         busy;

    always #5 clk = ~clk;

    gcd_issuer #(
        .WIDTH          (W),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .gcd_valid_o  (gcd_valid),
        .gcd_a_o      (gcd_a),
        .gcd_b_o      (gcd_b),
        .gcd_done_i   (gcd_done),
        .gcd_result_i (gcd_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_a_o      (rsp_a),
        .rsp_b_o      (rsp_b),
        .rsp_gcd_o    (rsp_gcd),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [3*W:0]   rsp_q[$];   // {a, b, gcd, err}
    logic [3*W-1:0] iss_q[$];   // {a, b, engine result}
    int             issue_cnt   = 0;
    bit             eng_stall   = 1'b0;
    int             eng_delay   = 2;
    bit             exp_timeout = 1'b0;

    bit             eng_busy = 1'b0;
    int             eng_cnt  = 0;
    logic [W-1:0]   eng_res  = '0;
    logic [3*W-1:0] eng_e;
    logic [3*W:0]   mon_e;
    int             n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
        int t;
        if (a == '0 || b == '0) begin
            rsp_q.push_back({a, b, a | b, 1'b0});
        end else begin
            iss_q.push_back({a, b, g});
            if (exp_timeout) rsp_q.push_back({a, b, {W{1'b0}}, 1'b1});
            else             rsp_q.push_back({a, b, g, 1'b0});
        end
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        t         = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_accept: req_ready stuck at %0b expected 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || rsp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle_timeout", (t < 1000), 1);
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wait_rsp_timeout", (t < 200), 1);
    endtask

    // Engine model: checks issued operands, answers after eng_delay WAIT cycles
    initial begin : engine
        gcd_done   = 1'b0;
        gcd_result = '0;
        forever begin
            @(negedge clk);
            gcd_done = 1'b0;
            if (eng_busy && !eng_stall) begin
                if (eng_cnt == 0) begin
                    gcd_done   = 1'b1;
                    gcd_result = eng_res;
                    eng_busy   = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end
            if (gcd_valid) begin
                issue_cnt++;
                chk("issue_expected", (iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    eng_e = iss_q.pop_front();
                    chk("issue_ops", {gcd_a, gcd_b}, eng_e[3*W-1:W]);
                    eng_res = eng_e[W-1:0];
                end
                eng_busy = 1'b1;
                eng_cnt  = eng_delay;
            end
        end
    end

    // Response monitor: compares every accepted response in order
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", (rsp_q.size() != 0), 1);
                if (rsp_q.size() != 0) begin
                    mon_e = rsp_q.pop_front();
                    chk("rsp", {rsp_a, rsp_b, rsp_gcd, rsp_err}, mon_e);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_req_ready", req_ready, 1);
        chk("rst_gcd_valid", gcd_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err",   rsp_err,   0);
        chk("rst_busy",      busy,      0);
        chk("rst_gcd_ops",   {gcd_a, gcd_b}, 0);
        chk("rst_rsp_data",  {rsp_a, rsp_b, rsp_gcd}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic transaction and issue latency
        push(8'd48, 8'd18, 8'd6);
        chk("lat_n1_gcd_valid", gcd_valid, 0);
        @(negedge clk);
        chk("lat_n2_gcd_valid", gcd_valid, 1);
        wait_idle();
        chk("ops_hold", {gcd_a, gcd_b}, {8'd48, 8'd18});

        // zero operands answered locally
        n = issue_cnt;
        push(8'd0, 8'd35, 8'd0);
        push(8'd0, 8'd0,  8'd0);
        wait_idle();
        chk("zero_no_issue", issue_cnt, n);
        chk("zero_ops_hold", {gcd_a, gcd_b}, {8'd48, 8'd18});

        // a few more patterns
        push(8'd12,  8'd8,  8'd4);
        push(8'd17,  8'd5,  8'd1);
        push(8'd255, 8'd85, 8'd85);
        push(8'd9,   8'd0,  8'd0);
        wait_idle();

        // fill the FIFO with the engine stalled
        eng_stall = 1'b1;
        push(8'd10,  8'd4,  8'd2);
        push(8'd9,   8'd6,  8'd3);
        push(8'd14,  8'd21, 8'd7);
        push(8'd100, 8'd75, 8'd25);
        push(8'd7,   8'd7,  8'd7);
        chk("full_ready", req_ready, 0);
        chk("full_busy",  busy,      1);
        repeat (5) @(negedge clk);
        chk("full_ready_stalled", req_ready, 0);
        eng_stall = 1'b0;
        wait_idle();
        chk("drain_ready", req_ready, 1);

        // response back-pressure
        rsp_ready = 1'b0;
        n = issue_cnt;
        push(8'd21, 8'd14, 8'd7);
        push(8'd9,  8'd3,  8'd3);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("rsp_hold", {rsp_valid, rsp_a, rsp_b, rsp_gcd}, {1'b1, 8'd21, 8'd14, 8'd7});
            @(negedge clk);
        end
        chk("hold_no_issue", issue_cnt, n + 1);
        rsp_ready = 1'b1;
        wait_idle();
        chk("hold_next_issue", issue_cnt, n + 2);

        // reset during WAIT with a queued request, then a late done
        eng_stall = 1'b1;
        push(8'd30, 8'd12, 8'd6);
        push(8'd8,  8'd4,  8'd4);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gcd_valid", gcd_valid, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy",      busy,      0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_gcd_ops",   {gcd_a, gcd_b}, 0);
        chk("mid_rst_rsp_data",  {rsp_a, rsp_b, rsp_gcd, rsp_err}, 0);
        rsp_q.delete();
        iss_q.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        eng_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("late_done_ignored", {rsp_valid, busy, gcd_valid}, 0);
        end

        // normal operation after reset
        push(8'd27, 8'd18, 8'd9);
        wait_idle();

`ifdef GCD_ISSUER_TIMEOUT_EN
        // engine never answers: timeout response after 20 WAIT cycles
        eng_stall   = 1'b1;
        exp_timeout = 1'b1;
        push(8'd40, 8'd16, 8'd8);
        wait_idle();
        exp_timeout = 1'b0;
        eng_stall   = 1'b0;
        repeat (5) @(negedge clk);
        // engine answers on the 20th WAIT cycle: done wins
        eng_delay = 19;
        push(8'd50, 8'd20, 8'd10);
        wait_idle();
        eng_delay = 2;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
